// File: rtl/subtrator_com_sinal_pkg.sv
// Shared constants for the mixed-sign subtractor: mode codes, result range limits
// and helpers that decode operand signedness from the mode code.
package subtrator_com_sinal_pkg;

  localparam int LARGURA_A_PADRAO = 8;
  localparam int LARGURA_B_PADRAO = 4;

  localparam logic [1:0] MODO_SS = 2'b00;
  localparam logic [1:0] MODO_UU = 2'b01;
  localparam logic [1:0] MODO_US = 2'b10;
  localparam logic [1:0] MODO_SU = 2'b11;

  // Result range limits; the result signedness follows operand A.
  localparam int MAX_COM_SINAL = (1 << (LARGURA_A_PADRAO - 1)) - 1;
  localparam int MIN_COM_SINAL = -(1 << (LARGURA_A_PADRAO - 1));
  localparam int MAX_SEM_SINAL = (1 << LARGURA_A_PADRAO) - 1;
  localparam int MIN_SEM_SINAL = 0;

  function automatic logic a_com_sinal(input logic [1:0] codigo);
    case (codigo)
      MODO_SS: a_com_sinal = 1'b1;
      MODO_SU: a_com_sinal = 1'b1;
      default: a_com_sinal = 1'b0;
    endcase
  endfunction

  function automatic logic b_com_sinal(input logic [1:0] codigo);
    case (codigo)
      MODO_SS: b_com_sinal = 1'b1;
      MODO_US: b_com_sinal = 1'b1;
      default: b_com_sinal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/subtrator_com_sinal_if.sv
// Valid/ready handshake bundle between the subtractor and its producer/consumer.
interface subtrator_com_sinal_if #(
  parameter int LARGURA_A = 8,
  parameter int LARGURA_B = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [LARGURA_A-1:0] entrada_a;
  logic [LARGURA_B-1:0] entrada_b;
  logic [1:0]           codigo;
  logic                 out_valid;
  logic                 out_ready;
  logic [LARGURA_A-1:0] saida;
  logic                 overflow;
  logic                 negativo;

  modport master (
    output in_valid, entrada_a, entrada_b, codigo, out_ready,
    input  in_ready, out_valid, saida, overflow, negativo
  );

  modport slave (
    input  in_valid, entrada_a, entrada_b, codigo, out_ready,
    output in_ready, out_valid, saida, overflow, negativo
  );
endinterface

// File: rtl/subtrator_com_sinal_extensor_sinal.sv
// Sign or zero extension of one operand to the internal subtraction width.
module extensor_sinal #(
  parameter int LARGURA_IN  = 4,
  parameter int LARGURA_OUT = 10
) (
  input  logic [LARGURA_IN-1:0]  valor,
  input  logic                   com_sinal,
  output logic [LARGURA_OUT-1:0] estendido
);

  // Replicate the MSB for signed operands, pad with zeros otherwise.
  always_comb begin
    if (com_sinal) begin
      estendido = {{(LARGURA_OUT - LARGURA_IN){valor[LARGURA_IN-1]}}, valor};
    end else begin
      estendido = {{(LARGURA_OUT - LARGURA_IN){1'b0}}, valor};
    end
  end

endmodule

// File: rtl/subtrator_com_sinal.sv
// Two-stage pipelined mixed-sign subtractor with valid/ready flow control.
// Define SUBTRATOR_SATURACAO_EN to clamp out-of-range results instead of wrapping.
module subtrator_com_sinal
  import subtrator_com_sinal_pkg::*;
#(
  parameter int LARGURA_A = LARGURA_A_PADRAO,
  parameter int LARGURA_B = LARGURA_B_PADRAO
) (
  input logic                clk,
  input logic                rst,
  subtrator_com_sinal_if.slave bus
);

  localparam int W = LARGURA_A + 2;
  localparam logic signed [W-1:0] MAX_S = W'(MAX_COM_SINAL);
  localparam logic signed [W-1:0] MIN_S = W'(MIN_COM_SINAL);
  localparam logic signed [W-1:0] MAX_U = W'(MAX_SEM_SINAL);
  localparam logic signed [W-1:0] MIN_U = W'(MIN_SEM_SINAL);

  logic [W-1:0]          a_ext_s;
  logic [W-1:0]          b_ext_s;
  logic                  s1_valid_r;
  logic signed [W-1:0]   s1_a_r;
  logic signed [W-1:0]   s1_b_r;
  logic [1:0]            s1_codigo_r;
  logic                  avanca_s;
  logic                  aceita_s;
  logic signed [W-1:0]   dif_s;
  logic                  com_sinal_res_s;
  logic                  acima_s;
  logic                  abaixo_s;
  logic [LARGURA_A-1:0]  saida_prox_s;
  logic                  negativo_prox_s;

  extensor_sinal #(.LARGURA_IN(LARGURA_A), .LARGURA_OUT(W)) u_ext_a (
    .valor     (bus.entrada_a),
    .com_sinal (a_com_sinal(bus.codigo)),
    .estendido (a_ext_s)
  );

  extensor_sinal #(.LARGURA_IN(LARGURA_B), .LARGURA_OUT(W)) u_ext_b (
    .valor     (bus.entrada_b),
    .com_sinal (b_com_sinal(bus.codigo)),
    .estendido (b_ext_s)
  );

  // S1 moves whenever S2 moves; in_ready is held low throughout reset.
  assign avanca_s     = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !rst && (!s1_valid_r || avanca_s);
  assign aceita_s     = bus.in_valid && bus.in_ready;

  // S1: extended operands and mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_a_r      <= '0;
      s1_b_r      <= '0;
      s1_codigo_r <= 2'b00;
    end else if (!s1_valid_r || avanca_s) begin
      s1_valid_r  <= aceita_s;
      s1_a_r      <= a_ext_s;
      s1_b_r      <= b_ext_s;
      s1_codigo_r <= bus.codigo;
    end
  end

  // Exact difference, range check for the result signedness, optional clamp.
  always_comb begin
    dif_s           = s1_a_r - s1_b_r;
    com_sinal_res_s = a_com_sinal(s1_codigo_r);
    if (com_sinal_res_s) begin
      acima_s  = dif_s > MAX_S;
      abaixo_s = dif_s < MIN_S;
    end else begin
      acima_s  = dif_s > MAX_U;
      abaixo_s = dif_s < MIN_U;
    end
    saida_prox_s = dif_s[LARGURA_A-1:0];
`ifdef SUBTRATOR_SATURACAO_EN
    if (acima_s) begin
      saida_prox_s = com_sinal_res_s ? MAX_S[LARGURA_A-1:0] : MAX_U[LARGURA_A-1:0];
    end else if (abaixo_s) begin
      saida_prox_s = com_sinal_res_s ? MIN_S[LARGURA_A-1:0] : MIN_U[LARGURA_A-1:0];
    end else begin
      saida_prox_s = dif_s[LARGURA_A-1:0];
    end
`endif
    negativo_prox_s = com_sinal_res_s ? saida_prox_s[LARGURA_A-1] : 1'b0;
  end

  // S2: registered result; payload only changes when a new valid result enters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.saida     <= '0;
      bus.overflow  <= 1'b0;
      bus.negativo  <= 1'b0;
    end else if (avanca_s) begin
      bus.out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        bus.saida    <= saida_prox_s;
        bus.overflow <= acima_s || abaixo_s;
        bus.negativo <= negativo_prox_s;
      end
    end
  end

endmodule

// File: doc/subtrator_com_sinal.md
# subtrator_com_sinal

Pipelined 8-bit subtractor covering the same four signedness combinations as the team's mixed-sign adder: an 8-bit operand minus a 4-bit operand, each interpreted as signed or unsigned by a 2-bit mode code. Correct sign or zero extension is applied, and borrow/overflow is detected per mode. Inputs arrive and results leave through valid/ready handshakes. The block sits beside the adder in the arithmetic datapath and supplies the inverse operation with proper flow control.

## Interface
- `LARGURA_A`, default 8: width of operand A and of the result.
- `LARGURA_B`, default 4: width of operand B.
- `clk`  in  1  single clock; all state is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input transaction offered.
- `in_ready`  out  1  block can accept an input this cycle.
- `entrada_a`  in  LARGURA_A  minuend.
- `entrada_b`  in  LARGURA_B  subtrahend.
- `codigo`  in  2  mode select; see Operation.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `saida`  out  LARGURA_A  difference.
- `overflow`  out  1  true result is outside the range of the mode.
- `negativo`  out  1  result is negative; signed-result modes only.

## Operation
- Both operands are extended to LARGURA_A+2 bits before subtraction. The exact difference D is computed at that width.
- Mode `00`: A signed, B signed (sign-extended). Result is signed; range −128..127.
- Mode `01`: A unsigned, B unsigned (zero-extended). Result is unsigned; range 0..255. Here `overflow` means borrow (A < B).
- Mode `10`: A unsigned, B signed. Result is unsigned; range 0..255.
- Mode `11`: A signed, B unsigned. Result is signed; range −128..127.
- `saida` defaults to the low LARGURA_A bits of D (wrap-around). See Configuration for saturation.
- `negativo` is the MSB of `saida` in modes `00` and `11`. It is 0 in modes `01` and `10`.

## Timing
- Two pipeline stages:
  - S1 registers the extended operands and `codigo`.
  - S2 registers `saida`, `overflow` and `negativo`.
- An input is accepted on any cycle where `in_valid && in_ready`.
- With `out_ready` held high, the result appears with `out_valid` 2 cycles after acceptance. Throughput is 1 result per cycle.
- S2 advances when S2 is empty or `out_ready` is high. S1 advances when S2 advances.
- `in_ready` is 1 when S1 is empty or S1 advances this cycle. It is combinational from `out_ready`.
- While `out_valid && !out_ready`:
  - `saida`, `overflow` and `negativo` hold stable.
  - At most 2 transactions are buffered, after which `in_ready` is 0.
- No transaction is lost or reordered.
- Simultaneous accept and release in the same cycle is legal; occupancy is unchanged.
- Reset is asynchronous: `out_valid`=0, `saida`=0, `overflow`=0, `negativo`=0, both stages empty.
  - `in_ready` is 0 while `rst` is high and 1 on the first cycle after release.
  - Reset mid-operation discards all in-flight transactions.

## Configuration
- Macro `SUBTRATOR_SATURACAO_EN`.
- Defined: when `overflow` is set, `saida` clamps to the mode's range limit on the side the result exceeded:
  - signed modes: 8'h7F or 8'h80;
  - unsigned modes: 8'hFF or 8'h00.
  - `negativo` follows the clamped value.
- Undefined: `saida` wraps.
- `overflow` behaves identically in both builds.

## Structure
- The shared package holds:
  - mode constants `MODO_SS`=2'b00, `MODO_UU`=2'b01, `MODO_US`=2'b10, `MODO_SU`=2'b11;
  - per-mode min/max constants for LARGURA_A.
- One sub-module, `extensor_sinal`: parameterised sign/zero extension of one operand to LARGURA_A+2 bits, selected by a single `com_sinal` input. It is instantiated twice in S1.

## Test plan
- Mode `00`, A=8'h05, B=4'hE (−2), `out_ready`=1 -> 2 cycles later `saida`=8'h07, `overflow`=0, `negativo`=0.
- Mode `00`, A=8'h80, B=4'h1:
  - wrap build -> `saida`=8'h7F, `overflow`=1;
  - saturation build -> `saida`=8'h80, `negativo`=1.
- Mode `01`, A=8'h03, B=4'h5:
  - wrap build -> `saida`=8'hFE, `overflow`=1, `negativo`=0;
  - saturation build -> `saida`=8'h00.
- Mode `10`:
  - A=8'hFA, B=4'hF -> `saida`=8'hFB, `overflow`=0;
  - A=8'hFF, B=4'hF -> `overflow`=1, `saida`=8'h00 (wrap build) or 8'hFF (saturation build).
- Backpressure: 4 back-to-back inputs with `out_ready`=0 for 3 cycles -> `in_ready` drops after 2 accepts; all 4 results emerge in order with outputs stable while stalled.
- Reset mid-stream: assert `rst` with both stages full -> `out_valid` drops immediately; after release, no stale result appears and the next input produces its result in 2 cycles.
